// File: rtl/fifo_rd_scheduler.sv
// Read-side controller for the P2 FIFO: a programmable tick paces reads, a
// round-robin arbiter picks one of two consumers per tick, and the returned
// word is delivered tagged with the winner's ID. Ticks lost to an empty FIFO
// are counted in a saturating underrun counter.
module fifo_rd_scheduler #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int UND_W  = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  div_cfg,
    input  logic [1:0]        req,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    output logic              busy,
    output logic [UND_W-1:0]  underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DELIVER
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  div_lat;
    logic              tick;
    logic              rr_ptr;
    logic              gnt_id;
    logic              winner;

    assign tick = enable && (cnt == div_lat);

    // Round-robin winner: pointer breaks a tie, a lone requester always wins.
    always_comb begin
        winner = rr_ptr;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

    // Tick counter; the period is re-latched only at wrap so div_cfg edits never cut a period short.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt     <= '0;
            div_lat <= div_cfg;
        end else if (!enable) begin
            cnt <= '0;
        end else if (tick) begin
            cnt     <= '0;
            div_lat <= div_cfg;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Read transaction FSM with registered strobes, delivery regs and underrun count.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            gnt_id       <= 1'b0;
            fifo_rd_en   <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_id       <= 1'b0;
            busy         <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick && (req != 2'b00)) begin
                        if (!fifo_empty) begin
                            gnt_id     <= winner;
                            rr_ptr     <= ~winner;
                            fifo_rd_en <= 1'b1;
                            busy       <= 1'b1;
                            state      <= ISSUE;
                        end else if (underrun_cnt != '1) begin
                            underrun_cnt <= underrun_cnt + UND_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    fifo_rd_en <= 1'b0;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    out_data  <= fifo_rd_data;
                    out_id    <= gnt_id;
                    out_valid <= 1'b1;
                    state     <= DELIVER;
                end
                DELIVER: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Self-checking bench for fifo_rd_scheduler: a transaction-level model
// (countdown-to-tick, age-since-grant) checked every cycle, plus directed
// scenarios with hand-computed cycle/data expectations.
module tb_fifo_rd_scheduler;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] div_cfg;
    logic [1:0] req;
    logic       force_empty;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = '0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_id;
    logic       busy;
    logic [7:0] underrun_cnt;

    logic       fifo_rd_en2;
    logic       out_valid2;
    logic [7:0] out_data2;
    logic       out_id2;
    logic       busy2;
    logic [1:0] underrun_cnt2;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    // bench FIFO: pushes from the stimulus process, pops on the DUT strobe
    logic [7:0] fifo_mem [0:63];
    int fifo_wp = 0;
    int fifo_rp = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       id;
    } dlv_t;

    int   rd_log[$];
    dlv_t val_log[$];

    // model state
    bit         m_init = 1'b0;
    int         m_left, m_period, m_age, m_und, m_und2;
    logic       m_rr, m_out_id, m_pend_id;
    logic [7:0] m_out_data, m_pend_data;

    always #5 clk_in = ~clk_in;

    assign fifo_empty = force_empty | (fifo_rp == fifo_wp);

    fifo_rd_scheduler #(.DATA_W(8), .CNT_W(4), .UND_W(8)) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .div_cfg(div_cfg),
        .req(req), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .busy(busy), .underrun_cnt(underrun_cnt)
    );

    fifo_rd_scheduler #(.DATA_W(8), .CNT_W(4), .UND_W(2)) dut_sat (
        .clk_in(clk_in), .reset(reset), .enable(enable), .div_cfg(div_cfg),
        .req(req), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en2),
        .fifo_rd_data(fifo_rd_data), .out_valid(out_valid2), .out_data(out_data2),
        .out_id(out_id2), .busy(busy2), .underrun_cnt(underrun_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
        end
    endtask

    always @(posedge clk_in) begin
        cyc_no <= cyc_no + 1;
        if (fifo_rd_en === 1'b1) begin
            fifo_rd_data <= fifo_mem[fifo_rp[5:0]];
            fifo_rp      <= fifo_rp + 1;
        end
    end

    // compare, log, then advance the model by one cycle
    always @(negedge clk_in) begin
        bit   tick, idle_now;
        logic winner;
        if (m_init) begin
            check("rd_en",     {31'd0, fifo_rd_en}, {31'd0, m_age == 1});
            check("busy",      {31'd0, busy},       {31'd0, m_age != 0});
            check("out_valid", {31'd0, out_valid},  {31'd0, m_age == 3});
            check("out_data",  {24'd0, out_data},   {24'd0, m_out_data});
            check("out_id",    {31'd0, out_id},     {31'd0, m_out_id});
            check("underrun",  {24'd0, underrun_cnt}, m_und);
            check("sat_rd_en", {31'd0, fifo_rd_en2}, {31'd0, m_age == 1});
            check("sat_valid", {31'd0, out_valid2},  {31'd0, m_age == 3});
            check("sat_data",  {24'd0, out_data2},   {24'd0, m_out_data});
            check("sat_id",    {31'd0, out_id2},     {31'd0, m_out_id});
            check("sat_busy",  {31'd0, busy2},       {31'd0, m_age != 0});
            check("sat_underrun", {30'd0, underrun_cnt2}, m_und2);
            if (fifo_rd_en === 1'b1) rd_log.push_back(cyc_no);
            if (out_valid === 1'b1) val_log.push_back('{cyc_no, out_data, out_id});
        end
        if (reset) begin
            m_init     = 1'b1;
            m_left     = div_cfg;
            m_period   = div_cfg;
            m_age      = 0;
            m_rr       = 1'b0;
            m_und      = 0;
            m_und2     = 0;
            m_out_data = '0;
            m_out_id   = 1'b0;
        end else if (m_init) begin
            tick = 1'b0;
            if (enable) begin
                if (m_left == 0) begin
                    tick     = 1'b1;
                    m_period = div_cfg;
                    m_left   = div_cfg;
                end else begin
                    m_left--;
                end
            end else begin
                m_left = m_period;
            end
            idle_now = (m_age == 0);
            if (m_age == 2) begin
                m_out_data = m_pend_data;
                m_out_id   = m_pend_id;
                m_age      = 3;
            end else if (m_age == 3) begin
                m_age = 0;
            end else if (m_age == 1) begin
                m_age = 2;
            end
            if (idle_now && tick && req != 2'b00) begin
                if (!fifo_empty) begin
                    winner      = (req == 2'b11) ? m_rr : req[1];
                    m_pend_id   = winner;
                    m_pend_data = fifo_mem[fifo_rp[5:0]];
                    m_rr        = ~winner;
                    m_age       = 1;
                end else begin
                    if (m_und < 255) m_und++;
                    if (m_und2 < 3) m_und2++;
                end
            end
        end
    end

    task automatic push(input logic [7:0] d);
        fifo_mem[fifo_wp[5:0]] = d;
        fifo_wp++;
    endtask

    // two reset cycles with the given period; returns in the first enabled cycle
    task automatic do_reset(input logic [3:0] dc, output int start);
        @(posedge clk_in); #1;
        reset = 1'b1; enable = 1'b0; req = 2'b00; div_cfg = dc;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b0;
        rd_log.delete();
        val_log.delete();
        start = cyc_no;
    endtask

    task automatic at_cycle(input int c);
        while (1) begin
            @(negedge clk_in);
            if (cyc_no >= c) break;
        end
    endtask

    initial begin
        int  s;
        bit  seen;
        reset = 1'b1; enable = 1'b0; div_cfg = 4'd8; req = 2'b00; force_empty = 1'b0;

        // 1: pacing at div_cfg=8
        push(8'hA1); push(8'hA2);
        do_reset(4'd8, s);
        enable = 1'b1; req = 2'b01;
        repeat (22) @(posedge clk_in);
        #1; req = 2'b00; enable = 1'b0;
        repeat (4) @(posedge clk_in);
        check("t1_rd_count", rd_log.size(), 2);
        check("t1_val_count", val_log.size(), 2);
        if (rd_log.size() >= 2) begin
            check("t1_first_rd", rd_log[0] - s, 9);
            check("t1_rd_gap", rd_log[1] - rd_log[0], 9);
        end
        if (val_log.size() >= 2 && rd_log.size() >= 2) begin
            check("t1_lat", val_log[0].cyc - rd_log[0], 2);
            check("t1_data0", {24'd0, val_log[0].data}, 32'hA1);
            check("t1_data1", {24'd0, val_log[1].data}, 32'hA2);
            check("t1_id", {30'd0, val_log[0].id, val_log[1].id}, 0);
        end

        // 2: round robin
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        do_reset(4'd5, s);
        enable = 1'b1; req = 2'b11;
        repeat (28) @(posedge clk_in);
        #1; req = 2'b00; enable = 1'b0;
        repeat (4) @(posedge clk_in);
        check("t2_val_count", val_log.size(), 4);
        if (val_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_id", {31'd0, val_log[i].id}, i % 2);
                check("t2_data", {24'd0, val_log[i].data}, 32'h10 + i);
            end
        end

        // 3: underrun count and saturation
        do_reset(4'd3, s);
        force_empty = 1'b1; enable = 1'b1; req = 2'b10;
        repeat (40) @(posedge clk_in);
        #1; enable = 1'b0;
        @(negedge clk_in);
        check("t3_und", {24'd0, underrun_cnt}, 10);
        check("t3_und_sat", {30'd0, underrun_cnt2}, 3);
        check("t3_no_rd", rd_log.size(), 0);
        req = 2'b00; force_empty = 1'b0;

        // 4: tick every cycle, service every 4
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        do_reset(4'd0, s);
        enable = 1'b1; req = 2'b01;
        repeat (20) @(posedge clk_in);
        #1; req = 2'b00; enable = 1'b0;
        repeat (4) @(posedge clk_in);
        check("t4_rd_count", rd_log.size(), 5);
        if (rd_log.size() == 5) begin
            check("t4_first_rd", rd_log[0] - s, 1);
            for (int i = 1; i < 5; i++) check("t4_rd_gap", rd_log[i] - rd_log[i-1], 4);
        end
        check("t4_und", {24'd0, underrun_cnt}, 0);

        // 5: reset during CAPTURE
        push(8'h55);
        do_reset(4'd2, s);
        enable = 1'b1; req = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_in);
            if (fifo_rd_en === 1'b1) seen = 1'b1;
        end
        check("t5_rd_seen", {31'd0, seen}, 1);
        @(posedge clk_in); #1;
        reset = 1'b1; req = 2'b00;
        @(posedge clk_in); #1;
        reset = 1'b0;
        @(negedge clk_in);
        check("t5_rd_en", {31'd0, fifo_rd_en}, 0);
        check("t5_valid", {31'd0, out_valid}, 0);
        check("t5_busy", {31'd0, busy}, 0);
        check("t5_data", {24'd0, out_data}, 0);
        check("t5_id", {31'd0, out_id}, 0);
        repeat (8) @(posedge clk_in);
        check("t5_no_dlv", val_log.size(), 0);
        #1;
        push(8'h66); push(8'h77);
        req = 2'b11;
        for (int i = 0; i < 20 && val_log.size() == 0; i++) @(negedge clk_in);
        check("t5_dlv_seen", val_log.size(), 1);
        if (val_log.size() >= 1) begin
            check("t5_rr_reset_id", {31'd0, val_log[0].id}, 0);
            check("t5_next_data", {24'd0, val_log[0].data}, 32'h66);
        end
        req = 2'b00; enable = 1'b0;
        repeat (6) @(posedge clk_in);

        // 6a: div_cfg 8 -> 2 mid-period, ticks observed via underruns
        do_reset(4'd8, s);
        force_empty = 1'b1; enable = 1'b1; req = 2'b01;
        repeat (4) @(posedge clk_in);
        #1; div_cfg = 4'd2;
        at_cycle(s + 8);  check("t6_und_e8",  {24'd0, underrun_cnt}, 0);
        at_cycle(s + 9);  check("t6_und_e9",  {24'd0, underrun_cnt}, 1);
        at_cycle(s + 11); check("t6_und_e11", {24'd0, underrun_cnt}, 1);
        at_cycle(s + 12); check("t6_und_e12", {24'd0, underrun_cnt}, 2);
        at_cycle(s + 15); check("t6_und_e15", {24'd0, underrun_cnt}, 3);
        at_cycle(s + 18); check("t6_und_e18", {24'd0, underrun_cnt}, 4);
        check("t6_und_sat", {30'd0, underrun_cnt2}, 3);
        req = 2'b00; force_empty = 1'b0; enable = 1'b0;

        // 6b: enable dropped in ISSUE
        while (fifo_rp != fifo_wp) push(8'h00);
        push(8'h9C); push(8'h9D);
        do_reset(4'd1, s);
        enable = 1'b1; req = 2'b01;
        repeat (2) @(posedge clk_in);
        #1; enable = 1'b0;
        @(negedge clk_in);
        check("t6_issue", {31'd0, fifo_rd_en}, 1);
        repeat (12) @(posedge clk_in);
        check("t6_rd_count", rd_log.size(), 1);
        check("t6_val_count", val_log.size(), 1);
        if (val_log.size() >= 1) begin
            check("t6_data", {24'd0, val_log[0].data}, 32'h9C);
            check("t6_id", {31'd0, val_log[0].id}, 0);
        end
        req = 2'b00;
        repeat (2) @(posedge clk_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
